// File: rtl/rand_3b_arb.sv
// Three-requester round-robin arbiter that hands out a random value from an external
// 3-bit shift-register generator with each grant. Define RAND_ZERO_GUARD_EN for the lockup guard.
module rand_3b_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] seed,
  input  logic       reseed,
  input  logic [2:0] req,
  input  logic [2:0] gen_rnd,
  output logic       gen_sel,
  output logic [2:0] gen_start,
  output logic [2:0] gnt,
  output logic [2:0] rnd_out,
  output logic       rnd_vld
);

  typedef enum logic {StSeed, StRun} state_e;

  state_e     state;
  logic [1:0] ptr;
  logic [2:0] elig;
  logic [1:0] cand;
  logic [1:0] win_idx;
  logic       found;
  logic       zero_hit;

  function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

`ifdef RAND_ZERO_GUARD_EN
  // An all-zero shift register never leaves zero, so never load it and bail out if seen.
  assign gen_start = (seed == 3'b000) ? 3'b001 : seed;
  assign zero_hit  = (gen_rnd == 3'b000);
`else
  assign gen_start = seed;
  assign zero_hit  = 1'b0;
`endif

  assign gen_sel = (state == StRun);

  // Masking with the live grant keeps a requester from winning twice while it drops req.
  always_comb begin
    elig    = req & ~gnt;
    found   = 1'b0;
    win_idx = ptr;
    cand    = 2'd0;
    for (int k = 0; k < 3; k++) begin
      cand = mod3_add(ptr, 2'(k));
      if (!found && elig[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= StSeed;
      ptr     <= 2'd0;
      gnt     <= 3'b000;
      rnd_out <= 3'b000;
      rnd_vld <= 1'b0;
    end else begin
      gnt     <= 3'b000;
      rnd_vld <= 1'b0;
      case (state)
        StSeed: state <= StRun;
        StRun: begin
          if (reseed || zero_hit) begin
            state <= StSeed;
          end else if (found) begin
            gnt     <= 3'b001 << win_idx;
            rnd_out <= gen_rnd;
            rnd_vld <= 1'b1;
            ptr     <= mod3_add(win_idx, 2'd1);
          end
        end
        default: state <= StSeed;
      endcase
    end
  end

endmodule

// File: tb/tb_rand_3b_arb.sv
// Directed self-checking bench for rand_3b_arb; inputs change right after a rising edge and
// outputs are sampled 1 time unit after it.
module tb_rand_3b_arb;

  logic       clk;
  logic       reset;
  logic [2:0] seed;
  logic       reseed;
  logic [2:0] req;
  logic [2:0] gen_rnd;
  logic       gen_sel;
  logic [2:0] gen_start;
  logic [2:0] gnt;
  logic [2:0] rnd_out;
  logic       rnd_vld;

  int n_checks = 0;
  int n_errors = 0;

  rand_3b_arb dut (
    .clk       (clk),
    .reset     (reset),
    .seed      (seed),
    .reseed    (reseed),
    .req       (req),
    .gen_rnd   (gen_rnd),
    .gen_sel   (gen_sel),
    .gen_start (gen_start),
    .gnt       (gnt),
    .rnd_out   (rnd_out),
    .rnd_vld   (rnd_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset spanning one edge, released on a falling edge, then the SEED cycle is consumed.
  task automatic reset_dut();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    step();
  endtask

  initial begin
    reset   = 1'b0;
    seed    = 3'b101;
    reseed  = 1'b0;
    req     = 3'b000;
    gen_rnd = 3'b000;
    #1 reset = 1'b1;
    #1;
    check("rst_gen_sel", 32'(gen_sel), 32'd0);
    check("rst_gen_start", 32'(gen_start), 32'h5);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_rnd_vld", 32'(rnd_vld), 32'd0);
    check("rst_rnd_out", 32'(rnd_out), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("seed_cycle_gen_sel", 32'(gen_sel), 32'd0);
    step();
    check("run_gen_sel", 32'(gen_sel), 32'd1);

    // Single requester with a known random value.
    req = 3'b010;
    gen_rnd = 3'b110;
    step();
    check("g1_gnt", 32'(gnt), 32'h2);
    check("g1_rnd_out", 32'(rnd_out), 32'h6);
    check("g1_rnd_vld", 32'(rnd_vld), 32'd1);
    req = 3'b000;
    gen_rnd = 3'b011;
    step();
    check("g1_drop_gnt", 32'(gnt), 32'd0);
    check("g1_drop_vld", 32'(rnd_vld), 32'd0);
    check("g1_hold_rnd", 32'(rnd_out), 32'h6);

    // Round-robin with all requesters held, starting from ptr=0.
    reset_dut();
    req = 3'b111;
    step();
    check("rr0", 32'(gnt), 32'h1);
    check("rr0_rnd", 32'(rnd_out), 32'h3);
    step();
    check("rr1", 32'(gnt), 32'h2);
    step();
    check("rr2", 32'(gnt), 32'h4);
    step();
    check("rr3", 32'(gnt), 32'h1);
    check("rr3_vld", 32'(rnd_vld), 32'd1);
    req = 3'b000;
    step();
    check("rr_idle", 32'(gnt), 32'd0);

    // Reseed beats a simultaneous request; request is served after SEED.
    reseed = 1'b1;
    req = 3'b001;
    step();
    check("rs_gnt", 32'(gnt), 32'd0);
    check("rs_gen_sel", 32'(gen_sel), 32'd0);
    reseed = 1'b0;
    step();
    check("rs_run_gen_sel", 32'(gen_sel), 32'd1);
    check("rs_run_gnt", 32'(gnt), 32'd0);
    step();
    check("rs_late_gnt", 32'(gnt), 32'h1);
    req = 3'b000;
    step();

    // Zero from the generator.
    seed = 3'b000;
    #1;
`ifdef RAND_ZERO_GUARD_EN
    check("z_gen_start", 32'(gen_start), 32'h1);
    req = 3'b100;
    gen_rnd = 3'b000;
    step();
    check("z_gnt", 32'(gnt), 32'd0);
    check("z_gen_sel", 32'(gen_sel), 32'd0);
    gen_rnd = 3'b101;
    step();
    check("z_run", 32'(gen_sel), 32'd1);
    step();
    check("z_late_gnt", 32'(gnt), 32'h4);
    check("z_late_rnd", 32'(rnd_out), 32'h5);
`else
    check("z_gen_start", 32'(gen_start), 32'd0);
    req = 3'b100;
    gen_rnd = 3'b000;
    step();
    check("z_gnt", 32'(gnt), 32'h4);
    check("z_rnd_out", 32'(rnd_out), 32'd0);
    check("z_gen_sel", 32'(gen_sel), 32'd1);
`endif
    req = 3'b000;
    seed = 3'b101;
    gen_rnd = 3'b010;
    step();

    // Asynchronous reset in the middle of a grant cycle (ptr is 0 here).
    req = 3'b010;
    step();
    check("mg_gnt", 32'(gnt), 32'h2);
    #2 reset = 1'b1;
    #1;
    check("mg_rst_gnt", 32'(gnt), 32'd0);
    check("mg_rst_vld", 32'(rnd_vld), 32'd0);
    check("mg_rst_gen_sel", 32'(gen_sel), 32'd0);
    check("mg_rst_rnd_out", 32'(rnd_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    req = 3'b111;
    step();
    check("mg_seed_gnt", 32'(gnt), 32'd0);
    check("mg_seed_done", 32'(gen_sel), 32'd1);
    step();
    check("mg_first_gnt", 32'(gnt), 32'h1);
    check("mg_first_rnd", 32'(rnd_out), 32'h2);
    req = 3'b000;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rand_3b_arb.md
RAND_3B_ARB -- requirements
Module: rand_3b_arb

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; forces the reset state immediately.
REQ-004 seed  input  3  seed value to load into the generator.
REQ-005 reseed  input  1  single-cycle request to reload the seed.
REQ-006 req  input  3  per-requester request bits; req[i] is held high until gnt[i] is seen.
REQ-007 gen_rnd  input  3  current value from the external 3-bit shift-register random generator.
REQ-008 gen_sel  output  1  generator mode: 0 = load gen_start, 1 = shift.
REQ-009 gen_start  output  3  load value driven to the generator.
REQ-010 gnt  output  3  one-hot grant, registered, one-cycle pulse.
REQ-011 rnd_out  output  3  random value delivered with the grant, registered.
REQ-012 rnd_vld  output  1  high for exactly the cycle in which gnt is nonzero.

Function
REQ-013 SHALL implement states SEED and RUN: gen_sel=0 in SEED, gen_sel=1 in RUN, driven combinationally from the state.
REQ-014 SEED SHALL last exactly one cycle and then go to RUN.
REQ-015 RUN SHALL stay in RUN until reseed=1 is sampled, or (with REQ-025) a zero is detected; either causes RUN->SEED.
REQ-016 gen_start SHALL equal seed combinationally at all times, subject to REQ-025.
REQ-017 Arbitration SHALL occur only at an edge where the state is RUN, reseed=0, and at least one eligible request exists.
REQ-018 A request is eligible when req[i]=1 and gnt[i]=0 in that cycle; this prevents a double grant while the requester drops req.
REQ-019 Arbitration SHALL be round-robin over a pointer ptr in {0,1,2}, searching ptr, ptr+1, ptr+2 (mod 3); after a grant to i, ptr SHALL become (i+1) mod 3.
REQ-020 On a grant edge, the block SHALL register gnt to the one-hot winner, rnd_out to the gen_rnd sampled at that edge, and rnd_vld to 1.
REQ-021 Grant latency from the cycle an eligible req is presented (with the state in RUN) SHALL be 1 cycle.
REQ-022 On non-grant edges gnt and rnd_vld SHALL be 0; rnd_out SHALL hold its last value.
REQ-023 reseed and req in the same cycle: reseed wins, no grant is issued, and pending requests are served after SEED.

Reset
REQ-024 While reset=1, the block SHALL hold: state SEED, ptr=0, gnt=000, rnd_out=000, rnd_vld=0, gen_sel=0. On release, the first edge SHALL complete SEED, and RUN begins after it. A reset asserted during a grant cycle SHALL clear gnt and rnd_vld immediately.

Configuration
REQ-025 With the macro RAND_ZERO_GUARD_EN defined, the block SHALL add a lockup guard:
- if seed=000, gen_start SHALL be 001;
- in RUN, gen_rnd=000 SHALL suppress any grant that cycle and force RUN->SEED.
Without the macro, there is no substitution and no detection, and 000 SHALL be granted like any other value.

Verification
REQ-026 Reset with seed=101: during reset gen_sel=0, gen_start=101, gnt=000, rnd_vld=0. After release, gen_sel=0 for one cycle, then 1.
REQ-027 In RUN, req=010 with gen_rnd=110: the next edge gives gnt=010, rnd_out=110, rnd_vld=1 for one cycle. Drop req, then gnt returns to 000.
REQ-028 In RUN from reset (ptr=0), req=111 held continuously: gnt sequence 001, 010, 100, 001 on consecutive cycles.
REQ-029 reseed=1 with req=001 in the same cycle: no grant, gen_sel=0 for one cycle, then gnt=001 one cycle after RUN resumes.
REQ-030 With RAND_ZERO_GUARD_EN and seed=000: gen_start=001. gen_rnd=000 with req=100: no grant and a one-cycle SEED. Without the macro: gnt=100 and rnd_out=000.
REQ-031 Assert reset mid-grant (gnt=010): gnt=000, rnd_vld=0 and gen_sel=0 immediately, without waiting for a clock edge. After release, ptr=0, so req=111 is granted 001 first.
